// File: rtl/bus_target_if.sv
// Shared PE request bus plus the global-memory port, as seen by bus_target.
interface bus_target_if #(
    parameter int unsigned NUM_PE = 4
);
    logic [NUM_PE-1:0] bus_request;
    logic [NUM_PE-1:0] grant;
    logic [31:0]       mem_addressBus;
    logic [31:0]       result_outBus;
    logic [4:0]        rs1OutBus;
    logic [4:0]        rs2OutBus;
    logic [4:0]        rdOutBus;
    logic              reg_selectBus;
    logic              mem_readBus;
    logic              mem_writeBus;
    logic              rd_writeBus;
    logic              read_enBus;
    logic [31:0]       AmuxBus;
    logic [31:0]       BmuxBus;
    logic              data_ReadyBus;
    logic [31:0]       memData;
    logic              mem_ackBus;
    logic              gm_req;
    logic              gm_we;
    logic [31:0]       gm_addr;
    logic [31:0]       gm_wdata;
    logic [31:0]       gm_rdata;
    logic              gm_ack;
    logic              err;

    modport slave (
        input  bus_request, mem_addressBus, result_outBus, rs1OutBus, rs2OutBus, rdOutBus,
               reg_selectBus, mem_readBus, mem_writeBus, rd_writeBus, read_enBus,
               gm_rdata, gm_ack,
        output grant, AmuxBus, BmuxBus, data_ReadyBus, memData, mem_ackBus,
               gm_req, gm_we, gm_addr, gm_wdata, err
    );

    modport master (
        output bus_request, mem_addressBus, result_outBus, rs1OutBus, rs2OutBus, rdOutBus,
               reg_selectBus, mem_readBus, mem_writeBus, rd_writeBus, read_enBus,
               gm_rdata, gm_ack,
        input  grant, AmuxBus, BmuxBus, data_ReadyBus, memData, mem_ackBus,
               gm_req, gm_we, gm_addr, gm_wdata, err
    );
endinterface

// File: rtl/bus_target.sv
// Shared PE bus responder: round-robin arbitration, 32x32 register-file service
// and global-memory access with a bounded wait for gm_ack.
module bus_target #(
    parameter int unsigned NUM_PE  = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    bus_target_if.slave bus
);
    localparam int unsigned PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREG  = 32;
    localparam logic [XLEN-1:0] ABORT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_CAPTURE, S_EXEC, S_MEMWAIT, S_RESP
    } state_e;

    // Captured copy of the granted PE's fields; the memory address lives in gm_addr_q.
    typedef struct packed {
        logic [XLEN-1:0] wdata;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_sel;
        logic            mem_read;
        logic            mem_write;
        logic            rd_write;
        logic            read_en;
    } req_t;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d, winner_q, winner_d, pick_c;
    logic              any_req_c, mem_op_c, rf_we_c;
    int unsigned       idx_c;
    req_t              req_q, req_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rf_q [NREG];
    logic [NUM_PE-1:0] grant_q, grant_d;
    logic [XLEN-1:0]   amux_q, amux_d, bmux_q, bmux_d, mem_data_q, mem_data_d;
    logic              ready_q, ready_d, mem_ack_q, mem_ack_d;
    logic              gm_req_q, gm_req_d, gm_we_q, gm_we_d, err_q, err_d;
    logic [XLEN-1:0]   gm_addr_q, gm_addr_d, gm_wdata_q, gm_wdata_d;

    assign mem_op_c = req_q.mem_read | req_q.mem_write;

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        any_req_c = 1'b0;
        pick_c    = '0;
        idx_c     = '0;
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            idx_c = (32'(rr_ptr_q) + i) % NUM_PE;
            if (!any_req_c && bus.bus_request[PTR_W'(idx_c)]) begin
                any_req_c = 1'b1;
                pick_c    = PTR_W'(idx_c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (any_req_c) state_d = S_GRANT;
            S_GRANT:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_EXEC;
            S_EXEC:    state_d = (!mem_op_c || bus.gm_ack) ? S_RESP : S_MEMWAIT;
            S_MEMWAIT: if (bus.gm_ack || cnt_q == CNT_W'(TIMEOUT - 1)) state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        winner_d   = winner_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        grant_d    = '0;
        ready_d    = 1'b0;
        mem_ack_d  = 1'b0;
        rf_we_c    = 1'b0;
        amux_d     = amux_q;
        bmux_d     = bmux_q;
        mem_data_d = mem_data_q;
        gm_req_d   = gm_req_q;
        gm_we_d    = gm_we_q;
        gm_addr_d  = gm_addr_q;
        gm_wdata_d = gm_wdata_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (any_req_c) begin
                    winner_d = pick_c;
                    grant_d  = NUM_PE'(1) << pick_c;
                end
            end
            S_CAPTURE: begin
                req_d.wdata     = bus.result_outBus;
                req_d.rs1       = bus.rs1OutBus;
                req_d.rs2       = bus.rs2OutBus;
                req_d.rd        = bus.rdOutBus;
                req_d.reg_sel   = bus.reg_selectBus;
                req_d.mem_read  = bus.mem_readBus;
                req_d.mem_write = bus.mem_writeBus;
                req_d.rd_write  = bus.rd_writeBus;
                req_d.read_en   = bus.read_enBus;
                cnt_d           = '0;
                // Launch gm_* on this edge so gm_req is already high during EXEC.
                if (bus.mem_readBus || bus.mem_writeBus) begin
                    gm_req_d   = 1'b1;
                    gm_we_d    = bus.mem_writeBus;
                    gm_addr_d  = bus.mem_addressBus;
                    gm_wdata_d = bus.result_outBus;
                end
            end
            S_EXEC: begin
                if (req_q.read_en) begin
                    amux_d = rf_q[req_q.rs1];
                    bmux_d = req_q.reg_sel ? rf_q[req_q.rs2] : '0;
                end
                rf_we_c = req_q.rd_write && (req_q.rd != 5'd0);
                if (req_q.mem_read && req_q.mem_write) err_d = 1'b1;
                if (!mem_op_c || bus.gm_ack) begin
                    gm_req_d  = 1'b0;
                    ready_d   = req_q.read_en;
                    mem_ack_d = mem_op_c;
                    if (req_q.mem_read && !req_q.mem_write) mem_data_d = bus.gm_rdata;
                end
            end
            S_MEMWAIT: begin
                if (bus.gm_ack) begin
                    gm_req_d  = 1'b0;
                    ready_d   = req_q.read_en;
                    mem_ack_d = 1'b1;
                    if (req_q.mem_read && !req_q.mem_write) mem_data_d = bus.gm_rdata;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    gm_req_d   = 1'b0;
                    ready_d    = req_q.read_en;
                    mem_ack_d  = 1'b1;
                    mem_data_d = ABORT_DATA;
                    err_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: rr_ptr_d = (winner_q == PTR_W'(NUM_PE - 1)) ? '0 : winner_q + PTR_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            winner_q   <= '0;
            req_q      <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            amux_q     <= '0;
            bmux_q     <= '0;
            mem_data_q <= '0;
            ready_q    <= 1'b0;
            mem_ack_q  <= 1'b0;
            gm_req_q   <= 1'b0;
            gm_we_q    <= 1'b0;
            gm_addr_q  <= '0;
            gm_wdata_q <= '0;
            err_q      <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            winner_q   <= winner_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            amux_q     <= amux_d;
            bmux_q     <= bmux_d;
            mem_data_q <= mem_data_d;
            ready_q    <= ready_d;
            mem_ack_q  <= mem_ack_d;
            gm_req_q   <= gm_req_d;
            gm_we_q    <= gm_we_d;
            gm_addr_q  <= gm_addr_d;
            gm_wdata_q <= gm_wdata_d;
            err_q      <= err_d;
            if (rf_we_c) rf_q[req_q.rd] <= req_q.wdata;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.AmuxBus       = amux_q;
    assign bus.BmuxBus       = bmux_q;
    assign bus.data_ReadyBus = ready_q;
    assign bus.memData       = mem_data_q;
    assign bus.mem_ackBus    = mem_ack_q;
    assign bus.gm_req        = gm_req_q;
    assign bus.gm_we         = gm_we_q;
    assign bus.gm_addr       = gm_addr_q;
    assign bus.gm_wdata      = gm_wdata_q;
    assign bus.err           = err_q;
endmodule

// File: tb/tb_bus_target.sv
// Randomized bench for bus_target, checked against a transaction-level model
// of the register file, global memory, round-robin pointer and response timing.
module tb_bus_target;
    localparam int NUM_PE  = 4;
    localparam int TIMEOUT = 8;
    localparam int NEVER   = 1000;

    typedef struct {
        int          pe;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rsel, mrd, mwr, rdw, ren;
        int          delay;
    } txn_t;

    logic clk;
    logic reset;

    bus_target_if #(.NUM_PE(NUM_PE)) bus ();
    bus_target #(.NUM_PE(NUM_PE), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] rf_m [32];
    logic [31:0] mem_m [logic [31:0]];
    logic [31:0] amux_m, bmux_m, mdata_m;
    logic        err_m;
    int          ptr_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (rf_m[i]) rf_m[i] = '0;
        amux_m  = '0;
        bmux_m  = '0;
        mdata_m = '0;
        err_m   = 1'b0;
        ptr_m   = 0;
    endtask

    function automatic logic [31:0] mem_fetch(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic drive_idle();
        bus.bus_request    = '0;
        bus.mem_addressBus = '0;
        bus.result_outBus  = '0;
        bus.rs1OutBus      = '0;
        bus.rs2OutBus      = '0;
        bus.rdOutBus       = '0;
        bus.reg_selectBus  = 1'b0;
        bus.mem_readBus    = 1'b0;
        bus.mem_writeBus   = 1'b0;
        bus.rd_writeBus    = 1'b0;
        bus.read_enBus     = 1'b0;
        bus.gm_ack         = 1'b0;
        bus.gm_rdata       = '0;
    endtask

    function automatic txn_t blank(input int pe);
        txn_t t;
        t.pe = pe; t.addr = '0; t.wdata = '0;
        t.rs1 = '0; t.rs2 = '0; t.rd = '0;
        t.rsel = 1'b0; t.mrd = 1'b0; t.mwr = 1'b0; t.rdw = 1'b0; t.ren = 1'b0;
        t.delay = 0;
        return t;
    endfunction

    // Single-requester transaction; caller is at a negedge with the DUT idle.
    task automatic do_txn(input txn_t t);
        logic        memop, acked;
        int          exp_lat, grant_at, grant_cnt, rdy_at, rdy_cnt, ack_at, ack_cnt, req_cycles;
        logic [31:0] exp_rd, grant_val;
        memop   = t.mrd | t.mwr;
        acked   = memop && (t.delay <= TIMEOUT);
        exp_lat = !memop ? 4 : (acked ? 4 + t.delay : 4 + TIMEOUT);
        exp_rd  = mem_fetch(t.addr);
        bus.bus_request    = NUM_PE'(1) << t.pe;
        bus.mem_addressBus = t.addr;
        bus.result_outBus  = t.wdata;
        bus.rs1OutBus      = t.rs1;
        bus.rs2OutBus      = t.rs2;
        bus.rdOutBus       = t.rd;
        bus.reg_selectBus  = t.rsel;
        bus.mem_readBus    = t.mrd;
        bus.mem_writeBus   = t.mwr;
        bus.rd_writeBus    = t.rdw;
        bus.read_enBus     = t.ren;
        grant_at = -1; grant_cnt = 0; grant_val = '0;
        rdy_at = -1; rdy_cnt = 0; ack_at = -1; ack_cnt = 0; req_cycles = 0;
        for (int c = 1; c <= exp_lat + 1; c++) begin
            @(negedge clk);
            bus.gm_ack = 1'b0;
            if (bus.grant != '0) begin
                grant_cnt++;
                if (grant_at < 0) begin
                    grant_at  = c;
                    grant_val = 32'(bus.grant);
                end
                bus.bus_request = '0;
            end
            if (bus.gm_req) begin
                if (req_cycles == 0) begin
                    check_eq("gm_we", 32'(bus.gm_we), 32'(t.mwr));
                    check_eq("gm_addr", bus.gm_addr, t.addr);
                    check_eq("gm_wdata", bus.gm_wdata, t.wdata);
                end
                if (req_cycles == t.delay) begin
                    bus.gm_ack   = 1'b1;
                    bus.gm_rdata = exp_rd;
                end
                req_cycles++;
            end
            if (bus.data_ReadyBus) begin rdy_cnt++; rdy_at = c; end
            if (bus.mem_ackBus)    begin ack_cnt++; ack_at = c; end
        end
        drive_idle();

        if (t.ren) begin
            amux_m = rf_m[t.rs1];
            bmux_m = t.rsel ? rf_m[t.rs2] : '0;
        end
        if (t.rdw && t.rd != 5'd0) rf_m[t.rd] = t.wdata;
        if (memop) begin
            if (!acked) begin
                mdata_m = 32'hDEAD_BEEF;
                err_m   = 1'b1;
            end else if (t.mwr) begin
                mem_m[t.addr] = t.wdata;
            end else begin
                mdata_m = exp_rd;
            end
            if (t.mrd && t.mwr) err_m = 1'b1;
        end
        ptr_m = (t.pe + 1) % NUM_PE;

        check_eq("grant_at", 32'(grant_at), 32'd1);
        check_eq("grant_cnt", 32'(grant_cnt), 32'd1);
        check_eq("grant_vec", grant_val, 32'(1) << t.pe);
        check_eq("ready_at", 32'(rdy_at), t.ren ? 32'(exp_lat) : 32'hFFFF_FFFF);
        check_eq("ready_cnt", 32'(rdy_cnt), t.ren ? 32'd1 : 32'd0);
        check_eq("memack_at", 32'(ack_at), memop ? 32'(exp_lat) : 32'hFFFF_FFFF);
        check_eq("memack_cnt", 32'(ack_cnt), memop ? 32'd1 : 32'd0);
        check_eq("gm_req_cycles", 32'(req_cycles),
                 memop ? 32'((acked ? t.delay : TIMEOUT) + 1) : 32'd0);
        check_eq("amux", bus.AmuxBus, amux_m);
        check_eq("bmux", bus.BmuxBus, bmux_m);
        check_eq("memdata", bus.memData, mdata_m);
        check_eq("err", 32'(bus.err), 32'(err_m));
    endtask

    // Hold a request mask with no operation flags and check n consecutive grants.
    task automatic rr_run(input logic [NUM_PE-1:0] mask, input int n);
        int got, c, last, w, idx;
        drive_idle();
        bus.bus_request = mask;
        got = 0; c = 0; last = 0;
        while (got < n && c < n * 6 + 10) begin
            @(negedge clk);
            c++;
            if (bus.grant != '0) begin
                w = -1;
                for (int k = 0; k < NUM_PE; k++) begin
                    idx = (ptr_m + k) % NUM_PE;
                    if (w < 0 && mask[idx]) w = idx;
                end
                check_eq("rr_grant", 32'(bus.grant), 32'(1) << w);
                check_eq("rr_gap", 32'(c - last), (got == 0) ? 32'd1 : 32'd5);
                ptr_m = (w + 1) % NUM_PE;
                last  = c;
                got++;
                if (got == n) bus.bus_request = '0;
            end
        end
        check_eq("rr_count", 32'(got), 32'(n));
        bus.bus_request = '0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        txn_t t;
        int   seen, cyc;
        reset = 1'b1;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_grant", 32'(bus.grant), 32'd0);
        check_eq("rst_amux", bus.AmuxBus, 32'd0);
        check_eq("rst_bmux", bus.BmuxBus, 32'd0);
        check_eq("rst_memdata", bus.memData, 32'd0);
        check_eq("rst_ready", 32'(bus.data_ReadyBus), 32'd0);
        check_eq("rst_memack", 32'(bus.mem_ackBus), 32'd0);
        check_eq("rst_gm_req", 32'(bus.gm_req), 32'd0);
        check_eq("rst_gm_we", 32'(bus.gm_we), 32'd0);
        check_eq("rst_gm_addr", bus.gm_addr, 32'd0);
        check_eq("rst_gm_wdata", bus.gm_wdata, 32'd0);
        check_eq("rst_err", 32'(bus.err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        t = blank(0); t.rdw = 1'b1; t.rd = 5'd5; t.wdata = 32'h1234;
        do_txn(t);
        t = blank(0); t.ren = 1'b1; t.rs1 = 5'd5; t.rs2 = 5'd0; t.rsel = 1'b1;
        do_txn(t);
        check_eq("dir_amux_1234", bus.AmuxBus, 32'h1234);
        check_eq("dir_bmux_zero", bus.BmuxBus, 32'd0);

        t = blank(1); t.rdw = 1'b1; t.rd = 5'd0; t.wdata = 32'hFFFF;
        do_txn(t);
        t = blank(1); t.ren = 1'b1; t.rs1 = 5'd0;
        do_txn(t);
        check_eq("dir_x0_reads_zero", bus.AmuxBus, 32'd0);

        t = blank(2); t.mwr = 1'b1; t.addr = 32'h100; t.wdata = 32'hCAFE; t.delay = 3;
        do_txn(t);
        t = blank(3); t.mrd = 1'b1; t.addr = 32'h100; t.delay = 3;
        do_txn(t);
        check_eq("dir_memdata_cafe", bus.memData, 32'hCAFE);

        rr_run(4'hF, 5);

        t = blank(1); t.mrd = 1'b1; t.addr = 32'h300; t.delay = NEVER;
        do_txn(t);
        check_eq("dir_timeout_data", bus.memData, 32'hDEAD_BEEF);
        check_eq("dir_timeout_err", 32'(bus.err), 32'd1);
        t = blank(1); t.ren = 1'b1; t.rs1 = 5'd5;
        do_txn(t);
        check_eq("dir_err_sticky", 32'(bus.err), 32'd1);

        for (int i = 0; i < 40; i++) begin
            t       = blank(int'($urandom_range(0, NUM_PE - 1)));
            t.rs1   = 5'($urandom_range(0, 7));
            t.rs2   = 5'($urandom_range(0, 7));
            t.rd    = 5'($urandom_range(0, 7));
            t.rsel  = 1'($urandom_range(0, 1));
            t.ren   = 1'($urandom_range(0, 1));
            t.rdw   = 1'($urandom_range(0, 1));
            t.mrd   = 1'($urandom_range(0, 1));
            t.mwr   = 1'($urandom_range(0, 1));
            t.addr  = 32'h100 + 32'($urandom_range(0, 3)) * 32'd4;
            t.wdata = $urandom;
            t.delay = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, TIMEOUT));
            do_txn(t);
        end
        rr_run(4'b1011, 4);

        t = blank(2); t.rdw = 1'b1; t.rd = 5'd5; t.wdata = 32'h55AA;
        do_txn(t);

        drive_idle();
        bus.bus_request    = 4'b0010;
        bus.mem_readBus    = 1'b1;
        bus.mem_addressBus = 32'h200;
        seen = 0; cyc = 0;
        while (seen < 3 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.grant != '0) bus.bus_request = '0;
            if (bus.gm_req) seen++;
        end
        check_eq("midrst_reached_memwait", 32'(seen), 32'd3);
        reset = 1'b1;
        drive_idle();
        @(negedge clk);
        reset = 1'b0;
        check_eq("midrst_gm_req", 32'(bus.gm_req), 32'd0);
        check_eq("midrst_grant", 32'(bus.grant), 32'd0);
        check_eq("midrst_err", 32'(bus.err), 32'd0);
        check_eq("midrst_memdata", bus.memData, 32'd0);
        check_eq("midrst_amux", bus.AmuxBus, 32'd0);
        model_reset();

        rr_run(4'b1100, 1);
        t = blank(2); t.ren = 1'b1; t.rs1 = 5'd5; t.rsel = 1'b1; t.rs2 = 5'd5;
        do_txn(t);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bus_target.md
# bus_target

Responder end of the shared PE bus: arbitrates among up to NUM_PE processing-element bus interfaces, captures the granted PE's bus fields, and services them against the local 32x32 register file and the global-memory port. It returns register operands (AmuxBus/BmuxBus, data_ReadyBus) and load data (memData, mem_ackBus) to the PE side. One instance sits between all PE bus interfaces and global memory.

## Interface
- NUM_PE, 4: number of requesters (2..8)
- TIMEOUT, 64: max cycles waiting for gm_ack before abort
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- bus_request  in  NUM_PE  per-PE request
- grant  out  NUM_PE  one-hot, one-cycle grant pulse
- mem_addressBus  in  32  global-memory byte address
- result_outBus  in  32  store data / rd write data
- rs1OutBus, rs2OutBus, rdOutBus  in  5 each  register selects
- reg_selectBus  in  1  0: read rs1 only, 1: read rs1 and rs2
- mem_readBus, mem_writeBus, rd_writeBus, read_enBus  in  1 each  operation flags
- AmuxBus, BmuxBus  out  32 each  register read data
- data_ReadyBus  out  1  register-read done pulse
- memData  out  32  load data
- mem_ackBus  out  1  memory-op done pulse
- gm_req, gm_we  out  1 each  global-memory request / write enable
- gm_addr, gm_wdata  out  32 each  global-memory address / write data
- gm_rdata  in  32  global-memory read data
- gm_ack  in  1  global-memory completion (valid with gm_rdata)
- err  out  1  sticky error flag

## Operation
- FSM: IDLE, GRANT, CAPTURE, EXEC, MEMWAIT, RESP.
- IDLE: if any bus_request bit is set, pick a winner round-robin starting at rr_ptr, then go to GRANT. Otherwise stay.
- GRANT: grant[winner]=1 for exactly this cycle. The PE latches its fields on this edge. Go to CAPTURE.
- CAPTURE: register all bus fields into internal copies. Go to EXEC.
- EXEC:
  - read_en: AmuxBus=rf[rs1]. BmuxBus=rf[rs2] if reg_select=1, else 0. Reads use pre-write contents.
  - rd_write: rf[rd]<=result_out. rd=0 is ignored; x0 always reads 0.
  - If there is no memory op, go to RESP. Otherwise drive gm_req=1, gm_addr=mem_address, gm_we=mem_write, gm_wdata=result_out, and go to MEMWAIT.
- Both mem_read and mem_write set: the write is performed, the read is dropped, and err is set.
- MEMWAIT: hold gm_* stable with gm_req=1 until gm_ack.
  - On gm_ack: drop gm_req; if the op is a read, capture gm_rdata into memData. Go to RESP.
  - If TIMEOUT cycles elapse with no ack: drop gm_req, memData=32'hDEADBEEF, set err, go to RESP.
- RESP: one-cycle pulse on data_ReadyBus if read_en was set, and on mem_ackBus if a memory op was set. Both may pulse together. Set rr_ptr=winner+1 mod NUM_PE. Go to IDLE.
- A captured request with no flags set: go straight to RESP with no pulses, and rr_ptr still advances.
- AmuxBus, BmuxBus and memData hold their values until overwritten.
- err clears only on reset.

## Timing
- Reset, synchronous and mid-operation included, forces:
  - state=IDLE, rr_ptr=0
  - all outputs 0: grant, AmuxBus, BmuxBus, memData, data_ReadyBus, mem_ackBus, gm_req, gm_we, gm_addr, gm_wdata, err
  - register file cleared to 0
  - an in-flight gm transaction is abandoned
- Register-only transaction: request seen at cycle T, grant at T+1, capture at T+2, EXEC at T+3, pulse at T+4. Total 4 cycles from IDLE.
- Memory transaction: gm_req rises at T+3. If gm_ack arrives at cycle A, the pulse is at A+1.
- gm_ack in the same cycle gm_req first rises is valid. gm_ack in any other state is ignored.
- The timeout counter starts at 0 in the first MEMWAIT cycle. The abort happens in the cycle the count reaches TIMEOUT-1 without ack.
- rr_ptr wraps from NUM_PE-1 to 0.
- A request that drops before GRANT is not granted. A new arbitration starts only from IDLE.

## Test plan
- Reset, then PE0 does rd_write rd=5, data 0x1234, then a second transaction read_en rs1=5, rs2=0, reg_select=1 -> data_ReadyBus pulse 4 cycles after its request; AmuxBus=0x1234, BmuxBus=0.
- rd_write rd=0, data 0xFFFF, then read rs1=0 -> AmuxBus=0.
- mem_write addr 0x100, data 0xCAFE with gm_ack after 3 cycles, then mem_read addr 0x100 with gm_rdata=0xCAFE -> gm_we=1 then 0; each gm_ack is followed next cycle by a mem_ackBus pulse; memData=0xCAFE.
- All 4 PEs hold bus_request continuously -> grants issued in the order 0,1,2,3,0, one per transaction.
- mem_read with gm_ack never asserted, TIMEOUT=8 -> gm_req drops after 8 MEMWAIT cycles; mem_ackBus pulses; memData=0xDEADBEEF; err=1 and stays 1.
- reset asserted during MEMWAIT -> next cycle gm_req=0, grant=0, err=0; the next request from PE2 is granted at T+1 with rr_ptr starting at 0.
